// File: rtl/mem_io_responder_if.sv
// Data-port bus between the single-cycle core and its memory-side responder.
// The core (master) drives the address, store strobe and store data. The
// responder (slave) returns combinational read data for that address.
interface mem_io_responder_if;
  logic        MemWrite;
  logic [31:0] ALUResult;
  logic [31:0] WriteData;
  logic [31:0] ReadData;

  modport master (
    output MemWrite,
    output ALUResult,
    output WriteData,
    input  ReadData
  );

  modport slave (
    input  MemWrite,
    input  ALUResult,
    input  WriteData,
    output ReadData
  );
endinterface

// File: rtl/mem_io_responder.sv
// Memory-side responder for the single-cycle core's data port.
// Address region 0x0xxxxxxx maps to a word-addressed data RAM that wraps.
// Address region 0xCxxxxxxx maps to I/O: the LED register, the synchronized
// switches and a compare-match timer. Reads are combinational; stores commit
// on the rising clock edge.
module mem_io_responder #(
  parameter int RAM_WORDS = 64,   // power of two, at least 2
  parameter int SW_WIDTH  = 10,   // at most 32
  parameter int LED_WIDTH = 10    // at most 32
) (
  input  logic                 clk,
  input  logic                 reset,      // synchronous, active-low
  mem_io_responder_if.slave    bus,
  input  logic [SW_WIDTH-1:0]  switches,
  output logic [LED_WIDTH-1:0] leds,
  output logic                 timer_irq
);

  localparam int IDX_W = $clog2(RAM_WORDS);

  localparam logic [7:0] OFF_LED   = 8'h00;
  localparam logic [7:0] OFF_SW    = 8'h04;
  localparam logic [7:0] OFF_TCTRL = 8'h08;
  localparam logic [7:0] OFF_TCMP  = 8'h0C;
  localparam logic [7:0] OFF_TCNT  = 8'h10;
  localparam logic [7:0] OFF_TSTAT = 8'h14;

  // Address decode
  logic             is_ram;
  logic             is_io;
  logic [IDX_W-1:0] ram_idx;
  logic [7:0]       io_off;
  logic             ram_we;
  logic             io_we;

  assign is_ram  = (bus.ALUResult[31:28] == 4'h0);
  assign is_io   = (bus.ALUResult[31:28] == 4'hC);
  assign ram_idx = bus.ALUResult[2 +: IDX_W];
  assign io_off  = bus.ALUResult[7:0];
  assign ram_we  = bus.MemWrite && is_ram;
  assign io_we   = bus.MemWrite && is_io;

  // Middle address bits play no part in decode; they alias into the regions.
  logic unused_addr_bits;
  assign unused_addr_bits = ^bus.ALUResult[27:8];

  // Storage
  logic [31:0]          ram_q [RAM_WORDS];
  logic [LED_WIDTH-1:0] led_q,     led_d;
  logic [SW_WIDTH-1:0]  sw_meta_q, sw_meta_d;
  logic [SW_WIDTH-1:0]  sw_sync_q, sw_sync_d;
  logic [1:0]           tctrl_q,   tctrl_d;   // [0] EN, [1] AUTORELOAD
  logic [31:0]          tcmp_q,    tcmp_d;
  logic [31:0]          tcnt_q,    tcnt_d;
  logic                 match_q,   match_d;
  logic                 timer_hit;

  // A match only counts while the timer is enabled.
  assign timer_hit = tctrl_q[0] && (tcnt_q == tcmp_q);

  // Next-state for registers: timer advance first, then software writes override.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    led_d     = led_q;
    sw_meta_d = switches;
    sw_sync_d = sw_meta_q;
    tctrl_d   = tctrl_q;
    tcmp_d    = tcmp_q;
    tcnt_d    = tcnt_q;
    match_d   = match_q;

    if (tctrl_q[0]) begin
      tcnt_d = (timer_hit && tctrl_q[1]) ? 32'd0 : tcnt_q + 32'd1;
    end

    if (io_we) begin
      case (io_off)
        OFF_LED:   led_d   = bus.WriteData[LED_WIDTH-1:0];
        OFF_TCTRL: tctrl_d = bus.WriteData[1:0];
        OFF_TCMP:  tcmp_d  = bus.WriteData;
        OFF_TCNT:  tcnt_d  = bus.WriteData;
        OFF_TSTAT: if (bus.WriteData[0]) match_d = 1'b0;
        default:   ;
      endcase
    end

    // A new match beats a same-edge W1C clear.
    if (timer_hit) begin
      match_d = 1'b1;
    end
  end

  // Register update with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (!reset) begin
      led_q     <= '0;
      sw_meta_q <= '0;
      sw_sync_q <= '0;
      tctrl_q   <= '0;
      tcmp_q    <= '0;
      tcnt_q    <= '0;
      match_q   <= 1'b0;
    end else begin
      led_q     <= led_d;
      sw_meta_q <= sw_meta_d;
      sw_sync_q <= sw_sync_d;
      tctrl_q   <= tctrl_d;
      tcmp_q    <= tcmp_d;
      tcnt_q    <= tcnt_d;
      match_q   <= match_d;
    end
  end

  // RAM store port; reset only gates the write, it does not clear contents.
  always_ff @(posedge clk) begin
    // NOTE: the RAM array has no reset so it maps onto plain memory;
    // software must initialise any word before reading it.
    if (reset && ram_we) begin
      ram_q[ram_idx] <= bus.WriteData;
    end
  end

  // Combinational read mux; unmapped space and undefined offsets read 0.
  always_comb begin
    bus.ReadData = 32'd0;
    if (is_ram) begin
      bus.ReadData = ram_q[ram_idx];
    end else if (is_io) begin
      case (io_off)
        OFF_LED:   bus.ReadData = 32'(led_q);
        OFF_SW:    bus.ReadData = 32'(sw_sync_q);
        OFF_TCTRL: bus.ReadData = {30'd0, tctrl_q};
        OFF_TCMP:  bus.ReadData = tcmp_q;
        OFF_TCNT:  bus.ReadData = tcnt_q;
        OFF_TSTAT: bus.ReadData = {31'd0, match_q};
        default:   bus.ReadData = 32'd0;
      endcase
    end
  end

  assign leds      = led_q;
  assign timer_irq = match_q;

endmodule

// File: doc/mem_io_responder.md
# mem_io_responder

Memory-side responder for the single-cycle ARM core's data port. It decodes the core's data address (`ALUResult`), accepts stores on `MemWrite` and returns `ReadData` combinationally in the same cycle, as the single-cycle datapath requires. It contains a word-addressed data RAM plus a small memory-mapped I/O region: an LED register, a synchronized switch input and a compare-match timer with an interrupt flag. It sits in the top level beside the instruction memory, on the opposite end of the core's `MemWrite`/`ALUResult`/`WriteData`/`ReadData` interface.

## Interface
- `RAM_WORDS`, default 64: data RAM depth in 32-bit words; must be a power of two.
- `SW_WIDTH`, default 10: switch input width.
- `LED_WIDTH`, default 10: LED output width.

Ports:
- `clk`  in  1  single clock; all state updates occur on its rising edge.
- `reset`  in  1  synchronous, active-low reset; sampled on the rising edge of `clk`.
- `MemWrite`  in  1  store strobe from the core; writes commit on the rising edge while it is high.
- `ALUResult`  in  32  byte address from the core; `[1:0]` ignored (word access only).
- `WriteData`  in  32  store data.
- `ReadData`  out  32  combinational read data for the word at `ALUResult`.
- `switches`  in  `SW_WIDTH`  asynchronous board switches.
- `leds`  out  `LED_WIDTH`  registered LED drive.
- `timer_irq`  out  1  registered timer match flag.

## Operation
- Decode on `ALUResult[31:28]`:
  - `0x0`: RAM. Word index is `ALUResult[2 +: log2(RAM_WORDS)]`, and higher address bits alias, so the region wraps.
  - `0xC`: I/O. Offset is `ALUResult[7:0]`.
  - Any other value: unmapped.
- I/O register map:
  - 0x00 `LED`: read/write, low `LED_WIDTH` bits; `leds` follows it.
  - 0x04 `SW`: read-only; returns the synchronized switch value, zero-extended.
  - 0x08 `TCTRL`: read/write; bit0 `EN`, bit1 `AUTORELOAD`; other bits read 0.
  - 0x0C `TCMP`: read/write, 32-bit compare value.
  - 0x10 `TCNT`: read/write, 32-bit counter.
  - 0x14 `TSTAT`: bit0 `MATCH`; writing 1 to bit0 clears it (W1C), writing 0 has no effect.
- Unmapped addresses and undefined I/O offsets read 0; writes to them are ignored.
- Writes to `SW` are ignored.
- Switch synchronizer: two flip-flop stages per bit.
- Timer, when `EN`=1:
  - If `TCNT==TCMP`: `MATCH` is set next edge. `TCNT` loads 0 if `AUTORELOAD`=1, otherwise increments.
  - Otherwise `TCNT` increments, wrapping 0xFFFFFFFF to 0.
- Timer, when `EN`=0: `TCNT` holds and no match is detected.
- `timer_irq` equals `MATCH`.

## Timing
- `ReadData` is purely combinational from `ALUResult` and the current storage contents (zero-latency read).
- Stores are visible on `ReadData` from the cycle after the edge that commits them.
- Read-during-write to the same address returns the old value during the write cycle.
- `SW` reflects a `switches` change after 2 edges; the bench samples in the third cycle.
- Reset values while `reset`=0 at an edge:
  - Cleared to 0: `LED`, `TCTRL`, `TCMP`, `TCNT`, `MATCH`, both synchronizer stages.
  - Therefore `leds`=0 and `timer_irq`=0 from the following cycle.
- RAM contents are not cleared by reset. RAM writes are suppressed on any edge where `reset`=0.
- Reset mid-operation: a store or timer match coinciding with a `reset`=0 edge is discarded; reset wins.
- Simultaneous events on one edge:
  - Software write to `TCNT` overrides the increment or reload.
  - A new match overrides a W1C clear of `MATCH` (set wins).
  - A write to `TCMP` takes effect for the comparison on the next cycle.
- `MATCH` stays set until cleared by W1C or reset; repeated matches keep it set.

## Test plan
- RAM store/load and wrap:
  - Write 0xDEADBEEF to 0x00000010, then read 0x00000010: 0xDEADBEEF.
  - Read 0x00000110 (aliases with `RAM_WORDS`=64): 0xDEADBEEF.
  - Read 0x20000010 (unmapped): 0.
- LED/switch:
  - Write 0x3FF to 0xC0000000: `leds`=0x3FF next cycle, and a readback returns 0x3FF.
  - Drive `switches`=0x155: reading 0xC0000004 returns 0x155 from the third cycle.
- Timer one-shot:
  - Write `TCMP`=5, then `TCTRL`=1.
  - `timer_irq` rises on the edge after `TCNT` reaches 5, while `TCNT` keeps counting (6, 7, ...).
  - Writing 1 to 0xC0000014 clears `timer_irq` next cycle.
- Timer auto-reload:
  - Write `TCMP`=3, then `TCTRL`=3: `TCNT` sequence is 0,1,2,3,0,1,...
  - A W1C issued on the same edge as a match leaves `timer_irq`=1.
- Reset:
  - With `leds`=0x2A, the timer running and `MemWrite`=1 to RAM word 4 (value 0x1234) during the `reset`=0 edge.
  - Result: `leds`=0, `TCNT`=0, `timer_irq`=0, and RAM word 4 keeps its prior value.
